led_bounce_chaser: RTL and testbench
====================================

# led_bounce_chaser

Parametrised LED chaser for the board LED bank. A rotating block of `BLK_LEN` lit LEDs and a single walker LED share one `LED_W`-wide display. The walker moves faster than the block, bounces off it and wraps at the display ends. All timing comes from one clock through internal tick enables; there are no derived clocks. The block drives the LED pins directly, and it exports a saturating bounce counter for the seven-segment display.

## Interface
- `LED_W`, 16: display width; must be ≥ 4.
- `BLK_LEN`, 3: lit length of the block; legal range is 1 .. `LED_W`-2.
- `FAST_DIV`, 23: walker steps every 2^`FAST_DIV` enabled cycles.
- `SLOW_DIV`, 26: block steps every 2^`SLOW_DIV` enabled cycles; must be > `FAST_DIV`.
- `clk` input 1: system clock. This is the only clock.
- `rst` input 1: reset, asynchronous, active-high.
- `en` input 1: run enable. When low, all state is frozen, including the prescaler.
- `dir` input 1: block direction, sampled on each slow tick. 0 = toward index 0, 1 = toward index `LED_W`-1.
- `led` output `LED_W`: OR of the block mask and the walker one-hot.
- `bounce_cnt` output 8: number of walker reversals, saturating at 255.

## Operation
- Prescaler `cnt` is `SLOW_DIV` bits wide. It increments on each cycle with `en`=1.
  - `fast_tick` = (`cnt[FAST_DIV-1:0]` is all ones) & `en`.
  - `slow_tick` = (`cnt` is all ones) & `en`. Every `slow_tick` coincides with a `fast_tick`.
- Block state is `blk_pos`, the index of the lowest lit LED. The block covers `blk_pos` .. `blk_pos`+`BLK_LEN`-1, with indices taken mod `LED_W`.
- On `slow_tick`, `blk_pos` becomes `blk_pos`±1 mod `LED_W`, per `dir`.
- Walker state is `wk_pos` plus `wk_dir` (0 = toward index 0). Candidate position `c` = `wk_pos`±1 mod `LED_W`.
- All occupancy checks use `nblk`, the block span after this cycle's update. `nblk` is the new span if `slow_tick`, otherwise the current span.
- On `fast_tick`:
  - If `c` is not in `nblk`: `wk_pos` ← `c`.
  - Else, if the opposite neighbour `o` is not in `nblk`: `wk_pos` ← `o`, `wk_dir` inverts, and `bounce_cnt` increments (saturating).
  - Else (trapped): hold position and direction, with no count.
- Push rule: on a `slow_tick` cycle where the result above would leave `wk_pos` inside `nblk`, the walker is relocated.
  - New position: the cell just beyond the block's leading edge in the block's direction of motion.
  - `wk_dir` ← `dir`.
  - This counts as one bounce only if `wk_dir` actually changed.
- Wrap-around is seamless for both block and walker (15→0 and 0→15 for `LED_W`=16).
- `led` is purely combinational from the registered state: the block mask OR `1<<wk_pos`.
- Reset values:
  - `cnt`=0.
  - `blk_pos`=`LED_W`-`BLK_LEN`.
  - `wk_pos`=`LED_W`-`BLK_LEN`-1, `wk_dir`=0.
  - `bounce_cnt`=0.
  - For the defaults, `led`=0xF000.

## Timing
- State updates on the rising `clk` edge where the tick is high. `led` and `bounce_cnt` reflect the move immediately after that edge, i.e. with zero extra latency.
- Simultaneous ticks: the block moves first and the walker is resolved against `nblk`. The push rule is evaluated last. All of this happens in one cycle.
- `en` low on a tick cycle: no tick occurs and `cnt` holds, so resuming continues the exact phase.
- `dir` change between slow ticks has no effect until the next `slow_tick`.
- `rst` asserted mid-operation: all registers return to their reset values asynchronously. The first tick after release occurs 2^`FAST_DIV` enabled cycles later.

## Structure
- Shared package `led_pkg`:
  - Direction constants `DIR_DOWN`=0 and `DIR_UP`=1.
  - Function `in_span(pos, base, len, width)` for the modular membership test.
  - Function `wrap_step(pos, dir, width)`.
- Sub-module `tick_gen`, parameters `FAST_DIV`, `SLOW_DIV`. Inputs `clk`, `rst`, `en`; outputs `fast_tick`, `slow_tick`. It is reused by later display blocks.
- Top level holds the block and walker registers, the next-state logic and the `led` decode.

## Test plan
All scenarios use `LED_W`=16, `BLK_LEN`=3, `FAST_DIV`=2, `SLOW_DIV`=4.
- Reset with `en`=1, `dir`=0 → `led`=0xF000. Walker at indices 11, 10, 9 after cycles 4, 8, 12. At cycle 16 both move: block to 12..14, walker to 8, `led`=0x7100.
- `en` held low for 50 cycles mid-run → `led`, `cnt` and `bounce_cnt` unchanged; the next tick lands exactly where it would have without the pause.
- Walker at 0, `wk_dir`=0, block 13..15 on a fast-only tick → `c`=15 is blocked, so walker goes to 1, `wk_dir`=1, `bounce_cnt`=1.
- Block at 5..7 with `dir`=1 on `slow_tick`, walker at 8 with `wk_dir`=1 → block moves to 6..8 and walker resolves to 9, with no bounce. Repeat with walker at 8, `wk_dir`=0 → pushed to 9, `wk_dir`=1, `bounce_cnt`+1.
- Force 300 bounces → `bounce_cnt` saturates at 255.
- Assert `rst` in the middle of a tick cycle → `led`=0xF000 and `bounce_cnt`=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/led_pkg.sv
// Shared helpers for the LED display blocks: direction codes and ring arithmetic.
// Latency: combinational functions only.
// Backpressure: not applicable.
package led_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // True when pos lies in base .. base+len-1, indices taken mod width.
  function automatic logic in_span(input int pos, input int base, input int len, input int width);
    int d;
    d = pos - base;
    if (d < 0) d = d + width;
    return (d < len);
  endfunction

  // One step along the ring of width cells, wrapping at both ends.
  function automatic int wrap_step(input int pos, input logic dir, input int width);
    int n;
    if (dir == DIR_UP) n = (pos == width - 1) ? 0 : pos + 1;
    else               n = (pos == 0) ? width - 1 : pos - 1;
    return n;
  endfunction

endpackage

// File: rtl/led_bounce_chaser_tick_gen.sv
// Free-running prescaler producing fast and slow single-cycle tick enables.
// Latency: ticks are combinational from the counter; a tick fires 2^DIV enabled cycles after reset.
// Backpressure: none; en low freezes the counter so the tick phase resumes exactly.
module tick_gen #(
  parameter int FAST_DIV = 23,
  parameter int SLOW_DIV = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic fast_tick,
  output logic slow_tick
);

  logic [SLOW_DIV-1:0] r_cnt;

  // Prescaler advances only on enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_cnt <= '0;
    else if (en) r_cnt <= r_cnt + SLOW_DIV'(1);
  end

  // The slow tick implies all low bits are ones, so it always coincides with a fast tick.
  assign fast_tick = en & (&r_cnt[FAST_DIV-1:0]);
  assign slow_tick = en & (&r_cnt);

endmodule

// File: rtl/led_bounce_chaser.sv
// LED chaser: rotating lit block plus a faster walker that bounces off it, with bounce counter.
// Latency: led and bounce_cnt reflect a move right after the tick edge, zero extra cycles.
// Backpressure: none; en low freezes every register including the prescaler.
module led_bounce_chaser
  import led_pkg::*;
#(
  parameter int LED_W    = 16,
  parameter int BLK_LEN  = 3,
  parameter int FAST_DIV = 23,
  parameter int SLOW_DIV = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  output logic [LED_W-1:0] led,
  output logic [7:0]       bounce_cnt
);

  localparam int PW = (LED_W > 1) ? $clog2(LED_W) : 1;

  logic          w_fast_tick;
  logic          w_slow_tick;

  logic [PW-1:0] r_blk_pos;
  logic [PW-1:0] r_wk_pos;
  logic          r_wk_dir;
  logic [7:0]    r_bounce_cnt;

  int            w_nblk;
  int            w_c;
  int            w_o;
  int            w_res;
  int            w_edge;
  logic [PW-1:0] w_nxt_wk_pos;
  logic          w_nxt_wk_dir;
  logic          w_bump;
  logic [LED_W-1:0] w_led;

  tick_gen #(
    .FAST_DIV (FAST_DIV),
    .SLOW_DIV (SLOW_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fast_tick (w_fast_tick),
    .slow_tick (w_slow_tick)
  );

  // Resolve the walker against the block span as it will be after this cycle.
  always_comb begin
    w_nxt_wk_dir = r_wk_dir;
    w_bump       = 1'b0;
    w_edge       = 0;
    w_nblk       = int'(r_blk_pos);
    if (w_slow_tick) w_nblk = wrap_step(int'(r_blk_pos), dir, LED_W);
    w_c   = wrap_step(int'(r_wk_pos), r_wk_dir, LED_W);
    w_o   = wrap_step(int'(r_wk_pos), ~r_wk_dir, LED_W);
    w_res = int'(r_wk_pos);

    if (w_fast_tick) begin
      if (!in_span(w_c, w_nblk, BLK_LEN, LED_W)) begin
        w_res = w_c;
      end else if (!in_span(w_o, w_nblk, BLK_LEN, LED_W)) begin
        w_res        = w_o;
        w_nxt_wk_dir = ~r_wk_dir;
        w_bump       = 1'b1;
      end
    end

    // A block landing on a trapped walker shoves it ahead of its leading edge.
    if (w_slow_tick && in_span(w_res, w_nblk, BLK_LEN, LED_W)) begin
      if (dir == DIR_UP) begin
        w_edge = w_nblk + BLK_LEN;
        if (w_edge >= LED_W) w_edge = w_edge - LED_W;
      end else begin
        w_edge = wrap_step(w_nblk, DIR_DOWN, LED_W);
      end
      w_res = w_edge;
      if (w_nxt_wk_dir != dir) w_bump = 1'b1;
      w_nxt_wk_dir = dir;
    end

    w_nxt_wk_pos = w_res[PW-1:0];
  end

  // Block moves one cell per slow tick in the sampled direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_blk_pos <= PW'(LED_W - BLK_LEN);
    else if (w_slow_tick) r_blk_pos <= w_nblk[PW-1:0];
  end

  // Walker state; next values equal current ones on cycles without a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wk_pos <= PW'(LED_W - BLK_LEN - 1);
      r_wk_dir <= DIR_DOWN;
    end else begin
      r_wk_pos <= w_nxt_wk_pos;
      r_wk_dir <= w_nxt_wk_dir;
    end
  end

  // Saturating count of walker reversals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_bounce_cnt <= '0;
    else if (w_bump && r_bounce_cnt != 8'hFF) r_bounce_cnt <= r_bounce_cnt + 8'd1;
  end

  // Display decode: block mask OR walker one-hot.
  always_comb begin
    w_led = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (in_span(i, int'(r_blk_pos), BLK_LEN, LED_W)) w_led[i] = 1'b1;
    end
    w_led[r_wk_pos] = 1'b1;
  end

  assign led        = w_led;
  assign bounce_cnt = r_bounce_cnt;

endmodule

// File: tb/tb_led_bounce_chaser.sv
// Bench for led_bounce_chaser with a mask-rotation reference model feeding a scoreboard queue.
// Latency: expected values are pushed when inputs are driven and popped one edge later.
// Backpressure: not applicable.
module tb_led_bounce_chaser;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dir;
  logic [15:0] led;
  logic [7:0]  bounce_cnt;

  typedef struct packed {
    logic [15:0] led;
    logic [7:0]  bcnt;
  } exp_t;

  exp_t sb_q[$];

  int n_tests;
  int n_fail;

  // Reference model state: block as a ring mask, walker as a one-hot.
  logic [15:0] m_mask;
  logic [15:0] m_wk;
  logic        m_wdir;
  logic [3:0]  m_cnt;
  logic [7:0]  m_bcnt;
  int          m_raw;

  logic [15:0] bring_tbl [4];

  led_bounce_chaser #(
    .LED_W    (16),
    .BLK_LEN  (3),
    .FAST_DIV (2),
    .SLOW_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dir        (dir),
    .led        (led),
    .bounce_cnt (bounce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] v);
    return {v[0], v[15:1]};
  endfunction

  task automatic model_reset();
    m_mask = 16'hE000;
    m_wk   = 16'h1000;
    m_wdir = 1'b0;
    m_cnt  = 4'd0;
    m_bcnt = 8'd0;
    m_raw  = 0;
  endtask

  task automatic model_bump();
    m_raw++;
    if (m_bcnt != 8'hFF) m_bcnt = m_bcnt + 8'd1;
  endtask

  task automatic model_step(input logic en_i, input logic dir_i);
    logic f;
    logic s;
    logic [15:0] c;
    logic [15:0] o;
    exp_t e;
    f = 1'b0;
    s = 1'b0;
    if (en_i) begin
      f = (m_cnt[1:0] == 2'b11);
      s = (m_cnt == 4'hF);
      m_cnt = m_cnt + 4'd1;
    end
    if (s) m_mask = dir_i ? rotl(m_mask) : rotr(m_mask);
    if (f) begin
      c = m_wdir ? rotl(m_wk) : rotr(m_wk);
      o = m_wdir ? rotr(m_wk) : rotl(m_wk);
      if ((c & m_mask) == 16'h0) begin
        m_wk = c;
      end else if ((o & m_mask) == 16'h0) begin
        m_wk   = o;
        m_wdir = ~m_wdir;
        model_bump();
      end
    end
    if (s && ((m_wk & m_mask) != 16'h0)) begin
      m_wk = (dir_i ? rotl(m_mask) : rotr(m_mask)) & ~m_mask;
      if (m_wdir != dir_i) model_bump();
      m_wdir = dir_i;
    end
    e.led  = m_mask | m_wk;
    e.bcnt = m_bcnt;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, record the expectation, compare after the edge.
  task automatic cycle(input logic en_i, input logic dir_i);
    exp_t e;
    en  = en_i;
    dir = dir_i;
    model_step(en_i, dir_i);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("led", {16'h0, led}, {16'h0, e.led});
      check_eq("bcnt", {24'h0, bounce_cnt}, {24'h0, e.bcnt});
    end
  endtask

  initial begin
    logic d;
    int   n;
    n_tests = 0;
    n_fail  = 0;
    bring_tbl[0] = 16'hE800;
    bring_tbl[1] = 16'hE400;
    bring_tbl[2] = 16'hE200;
    bring_tbl[3] = 16'h7100;
    rst = 1'b1;
    en  = 1'b0;
    dir = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_led", {16'h0, led}, 32'h0000F000);
    check_eq("rst_bcnt", {24'h0, bounce_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bring-up: walker steps at 4, 8, 12; both move at 16.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0);
      if (i % 4 == 0) check_eq("bringup", {16'h0, led}, {16'h0, bring_tbl[i/4 - 1]});
    end

    // Mixed direction running.
    d = 1'b1;
    for (int i = 0; i < 37; i++) begin
      cycle(1'b1, d);
      if ($urandom_range(0, 5) == 0) d = ~d;
    end

    // Pause with en low while dir wiggles, then resume on the same phase.
    for (int i = 0; i < 50; i++) begin
      d = 1'($urandom_range(0, 1));
      cycle(1'b0, d);
    end
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, d);
      if ($urandom_range(0, 7) == 0) d = ~d;
    end

    // Run long enough for 300 reversals so the counter saturates.
    n = 0;
    while (m_raw < 300 && n < 60000) begin
      cycle(1'b1, d);
      if ($urandom_range(0, 15) == 0) d = ~d;
      n++;
    end
    check_eq("sat_budget", {31'h0, (n < 60000)}, 32'd1);
    check_eq("sat_bcnt", {24'h0, bounce_cnt}, 32'd255);

    // Land right before a tick edge, then assert reset mid-cycle.
    while (m_cnt[1:0] != 2'b11) cycle(1'b1, d);
    en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_led", {16'h0, led}, 32'h0000F000);
    check_eq("arst_bcnt", {24'h0, bounce_cnt}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_eq("arst_hold", {16'h0, led}, 32'h0000F000);
    @(negedge clk);
    rst = 1'b0;

    // First tick after release is four enabled cycles later.
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0);
      if (i == 3) check_eq("post_rst_idle", {16'h0, led}, 32'h0000F000);
      if (i == 4) check_eq("post_rst_tick", {16'h0, led}, 32'h0000E800);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
